rtc_timekeeper: RTL and testbench
=================================

// Module: rtc_timekeeper
// PURPOSE
// Parametrised local BCD timekeeper for the I2C RTC core (mcp7940n): keeps time from
// clk between RTC reads, resyncs on every RTC tick, and gives the CPU a register file
// with write-through to the RTC. Adds N time-of-day alarms and a 1 Hz strobe.
// Sits between the mcp7940n instance and the CPU I/O bus.
// PARAMETERS
// CLK_HZ     25000000  clk frequency; local second = CLK_HZ cycles
// N_ALARMS   2         number of HH:MM:SS alarm comparators, 1..8
// SYNC_RESET 1         1: SYNC_EN bit resets to 1; 0: resets to 0
// PORTS
// clk           in   1   system clock
// reset         in   1   async, active-low (0 = reset)
// rtc_tick      in   1   1-cycle strobe from RTC core: rtc_datetime valid
// rtc_datetime  in   56  BCD {YY,MO,DD,WD,HH,MI,SS} from RTC core
// rtc_wr        out  1   1-cycle write request to RTC core
// rtc_addr      out  3   RTC field index 0..6 for rtc_wr
// rtc_data      out  8   BCD byte for rtc_wr
// cpu_wr        in   1   register write strobe
// cpu_addr      in   5   register address
// cpu_wdata     in   8   write data
// cpu_rdata     out  8   read data, registered
// datetime      out  56  local BCD time, same packing as rtc_datetime
// pps           out  1   1-cycle pulse at each local second increment
// alarm         out  N_ALARMS  sticky alarm flags
// BEHAVIOUR
// - Reset: datetime=0x00_01_01_01_00_00_00 (YY=00,MO=01,DD=01,WD=01), pps=0, alarm=0,
//   rtc_wr=0, rtc_addr=0, rtc_data=0, cpu_rdata=0, divider=0, SYNC_EN=SYNC_RESET,
//   alarm enables=0, alarm times=0.
// - Map: 0..6 = SS,MI,HH,WD,DD,MO,YY; 7 = CTRL {bit0 SYNC_EN, bits7:1 read 0};
//   8 = ALARM_EN[N-1:0]; 9 = ALARM_FLAG (write 1 to clear); 16+3i+{0,1,2} = alarm i
//   SS,MI,HH. Unmapped reads 0, unmapped writes ignored.
// - cpu_rdata valid the cycle after cpu_addr is presented (1-cycle latency).
// - Divider counts 0..CLK_HZ-1; on wrap, pps=1 for one cycle and the time increments.
// - Increment, all BCD: SS 59->00 carries MI; MI 59->00 carries HH; HH 23->00 carries
//   DD and WD. WD 7->1. DD at month length->01 carries MO. Month length: 31/30, Feb 29 if
//   YY%4==0 else 28. MO 12->01 carries YY. YY 99->00.
// - Out-of-range fields, e.g. SS=0x7A: unsigned compare >= limit -> wrap to min and carry.
//   A bad low digit (A..F) below the limit rolls to the next tens digit.
// - rtc_tick with SYNC_EN=1: datetime<=rtc_datetime; divider<=0; no pps that cycle.
//   With SYNC_EN=0, rtc_tick is ignored.
// - CPU write to 0..6: the field takes cpu_wdata unmodified. Writing SS also clears the
//   divider. Next cycle rtc_wr=1, rtc_addr=field, rtc_data=cpu_wdata, for one cycle.
//   Back-to-back writes give back-to-back rtc_wr pulses in order.
// - Same-cycle priority: CPU field write > rtc_tick load > pps increment. A pps that loses
//   to a CPU write is deferred one cycle; it is still pulsed and applied. rtc_tick in a
//   CPU-write cycle loads all fields except the written one.
// - Alarms: alarm i sets when its enable is set and, in the cycle after pps, {HH,MI,SS}
//   equals alarm i. Set beats a clear in the same cycle. A load or CPU write never fires
//   an alarm.
// - Reset asserted mid-operation returns all state to reset values immediately (async).
//   A pending rtc_wr is dropped.
// TESTING
// - Reset, run CLK_HZ cycles: pps pulses once at cycle CLK_HZ; SS 00->01; alarm=0.
// - Preload 23:59:59 Sun(WD=7) 28-02-23, one pps: 00:00:00 WD=1 01-03-23. Repeat with YY=24:
//   29-02-24. From 31-12-99: 01-01-00.
// - rtc_tick with rtc_datetime=0x25_06_15_03_12_34_56, SYNC_EN=1: datetime matches next
//   cycle, divider=0. Same with SYNC_EN=0: datetime unchanged.
// - CPU write addr1=0x45: MI=0x45; next cycle rtc_wr=1, rtc_addr=1, rtc_data=0x45. Write
//   coincident with pps: pps delayed one cycle, SS still increments.
// - Alarm0 = 12:00:05, ALARM_EN=1, time 12:00:04: after next pps alarm[0]=1. Write
//   ALARM_FLAG=1: alarm[0]=0. Read addr 9 returns 0 one cycle later.
// - Assert reset mid-second with rtc_wr pending: all outputs at reset values, no rtc_wr
//   after release.

Source files
------------

// File: rtl/rtc_timekeeper.sv
// Local BCD timekeeper for the RTC core: free-runs from clk, resyncs on RTC ticks,
// exposes a CPU register file with write-through to the RTC and N time-of-day alarms.
module rtc_timekeeper #(
   parameter int unsigned CLK_HZ     = 25000000,
   parameter int unsigned N_ALARMS   = 2,
   parameter bit          SYNC_RESET = 1'b1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                rtc_tick,
   input  logic [55:0]         rtc_datetime,
   output logic                rtc_wr,
   output logic [2:0]          rtc_addr,
   output logic [7:0]          rtc_data,
   input  logic                cpu_wr,
   input  logic [4:0]          cpu_addr,
   input  logic [7:0]          cpu_wdata,
   output logic [7:0]          cpu_rdata,
   output logic [55:0]         datetime,
   output logic                pps,
   output logic [N_ALARMS-1:0] alarm
);

   localparam int unsigned     DIV_W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_HZ - 1);
   localparam logic [55:0]     DT_RESET = 56'h00_01_01_01_00_00_00;

   logic [DIV_W-1:0]    div_q, div_d;
   logic [55:0]         dt_q, dt_d;
   logic                pps_q, pps_d;
   logic                pend_q, pend_d;
   logic                sync_en_q, sync_en_d;
   logic [N_ALARMS-1:0] alarm_en_q, alarm_en_d;
   logic [N_ALARMS-1:0] flag_q, flag_d;
   logic [N_ALARMS-1:0] match;
   logic [7:0]          alm_q [N_ALARMS][3];
   logic                rtc_wr_q, rtc_wr_d;
   logic [2:0]          rtc_addr_q, rtc_addr_d;
   logic [7:0]          rtc_data_q, rtc_data_d;
   logic [7:0]          rdata_q, rdata_d;

   logic wrap, load, fire, field_wr, inc_apply;

   // Out-of-range values wrap to min with carry; a bad low digit rolls the tens digit.
   function automatic logic [8:0] bcd_step(input logic [7:0] val, input logic [7:0] lim,
                                           input logic [7:0] min);
      if (val >= lim) begin
         return {1'b1, min};
      end else if (val[3:0] >= 4'd9) begin
         return {1'b0, val[7:4] + 4'd1, 4'd0};
      end else begin
         return {1'b0, val + 8'd1};
      end
   endfunction

   function automatic logic [7:0] month_len(input logic [7:0] mo, input logic [7:0] yy);
      logic [1:0] yy_mod4;
      yy_mod4 = {yy[4], 1'b0} + yy[1:0];
      case (mo)
         8'h02:                      return (yy_mod4 == 2'd0) ? 8'h29 : 8'h28;
         8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
         default:                    return 8'h31;
      endcase
   endfunction

   function automatic logic [55:0] dt_inc(input logic [55:0] dt);
      logic [55:0] n;
      logic [8:0]  r;
      logic        c;
      n = dt;
      r = bcd_step(dt[7:0], 8'h59, 8'h00);
      n[7:0] = r[7:0];
      c = r[8];
      if (c) begin
         r = bcd_step(dt[15:8], 8'h59, 8'h00);
         n[15:8] = r[7:0];
         c = r[8];
      end
      if (c) begin
         r = bcd_step(dt[23:16], 8'h23, 8'h00);
         n[23:16] = r[7:0];
         c = r[8];
      end
      if (c) begin
         r = bcd_step(dt[31:24], 8'h07, 8'h01);
         n[31:24] = r[7:0];
         r = bcd_step(dt[39:32], month_len(dt[47:40], dt[55:48]), 8'h01);
         n[39:32] = r[7:0];
         c = r[8];
      end
      if (c) begin
         r = bcd_step(dt[47:40], 8'h12, 8'h01);
         n[47:40] = r[7:0];
         c = r[8];
      end
      if (c) begin
         r = bcd_step(dt[55:48], 8'h99, 8'h00);
         n[55:48] = r[7:0];
      end
      return n;
   endfunction

   always_comb begin
      wrap      = (div_q == DIV_MAX);
      load      = rtc_tick && sync_en_q;
      field_wr  = cpu_wr && (cpu_addr < 5'd7);
      fire      = wrap || pend_q;
      // A field write steals the increment slot; the pending second lands next cycle.
      inc_apply = fire && !load && !field_wr;
      pend_d    = fire && !load && field_wr;
      pps_d     = inc_apply;

      div_d = wrap ? '0 : div_q + DIV_W'(1);
      if (load || (field_wr && cpu_addr == 5'd0)) begin
         div_d = '0;
      end

      dt_d = dt_q;
      if (inc_apply) begin
         dt_d = dt_inc(dt_q);
      end
      if (load) begin
         dt_d = rtc_datetime;
      end
      for (int f = 0; f < 7; f++) begin
         if (field_wr && cpu_addr == 5'(f)) begin
            dt_d[8*f +: 8] = cpu_wdata;
         end
      end

      sync_en_d  = (cpu_wr && cpu_addr == 5'd7) ? cpu_wdata[0] : sync_en_q;
      alarm_en_d = (cpu_wr && cpu_addr == 5'd8) ? cpu_wdata[N_ALARMS-1:0] : alarm_en_q;

      for (int i = 0; i < int'(N_ALARMS); i++) begin
         match[i] = pps_q && alarm_en_q[i] &&
                    (dt_q[23:0] == {alm_q[i][2], alm_q[i][1], alm_q[i][0]});
      end
      flag_d = flag_q;
      if (cpu_wr && cpu_addr == 5'd9) begin
         flag_d = flag_q & ~cpu_wdata[N_ALARMS-1:0];
      end
      flag_d = flag_d | match;

      rtc_wr_d   = field_wr;
      rtc_addr_d = field_wr ? cpu_addr[2:0] : rtc_addr_q;
      rtc_data_d = field_wr ? cpu_wdata : rtc_data_q;

      rdata_d = '0;
      for (int f = 0; f < 7; f++) begin
         if (cpu_addr == 5'(f)) begin
            rdata_d = dt_q[8*f +: 8];
         end
      end
      if (cpu_addr == 5'd7) rdata_d = {7'b0, sync_en_q};
      if (cpu_addr == 5'd8) rdata_d = 8'(alarm_en_q);
      if (cpu_addr == 5'd9) rdata_d = 8'(flag_q);
      for (int i = 0; i < int'(N_ALARMS); i++) begin
         for (int k = 0; k < 3; k++) begin
            if (int'(cpu_addr) == 16 + 3 * i + k) rdata_d = alm_q[i][k];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_q      <= '0;
         dt_q       <= DT_RESET;
         pps_q      <= 1'b0;
         pend_q     <= 1'b0;
         sync_en_q  <= SYNC_RESET;
         alarm_en_q <= '0;
         flag_q     <= '0;
         rtc_wr_q   <= 1'b0;
         rtc_addr_q <= '0;
         rtc_data_q <= '0;
         rdata_q    <= '0;
         for (int i = 0; i < int'(N_ALARMS); i++) begin
            for (int k = 0; k < 3; k++) alm_q[i][k] <= '0;
         end
      end else begin
         div_q      <= div_d;
         dt_q       <= dt_d;
         pps_q      <= pps_d;
         pend_q     <= pend_d;
         sync_en_q  <= sync_en_d;
         alarm_en_q <= alarm_en_d;
         flag_q     <= flag_d;
         rtc_wr_q   <= rtc_wr_d;
         rtc_addr_q <= rtc_addr_d;
         rtc_data_q <= rtc_data_d;
         rdata_q    <= rdata_d;
         for (int i = 0; i < int'(N_ALARMS); i++) begin
            for (int k = 0; k < 3; k++) begin
               if (cpu_wr && int'(cpu_addr) == 16 + 3 * i + k) alm_q[i][k] <= cpu_wdata;
            end
         end
      end
   end

   assign datetime  = dt_q;
   assign pps       = pps_q;
   assign alarm     = flag_q;
   assign rtc_wr    = rtc_wr_q;
   assign rtc_addr  = rtc_addr_q;
   assign rtc_data  = rtc_data_q;
   assign cpu_rdata = rdata_q;

endmodule

// File: tb/tb_rtc_timekeeper.sv
// Directed bench for rtc_timekeeper: table of one-second increments from loaded times,
// plus hand sequences for sync, CPU write-through, deferred pps, alarms and async reset.
module tb_rtc_timekeeper;

   localparam int unsigned CLK_HZ   = 10;
   localparam int unsigned N_ALARMS = 2;
   localparam logic [55:0] DT_RESET = 56'h00_01_01_01_00_00_00;

   logic                clk = 1'b0;
   logic                reset;
   logic                rtc_tick;
   logic [55:0]         rtc_datetime;
   logic                rtc_wr;
   logic [2:0]          rtc_addr;
   logic [7:0]          rtc_data;
   logic                cpu_wr;
   logic [4:0]          cpu_addr;
   logic [7:0]          cpu_wdata;
   logic [7:0]          cpu_rdata;
   logic [55:0]         datetime;
   logic                pps;
   logic [N_ALARMS-1:0] alarm;

   always #5 clk = ~clk;

   rtc_timekeeper #(
      .CLK_HZ     (CLK_HZ),
      .N_ALARMS   (N_ALARMS),
      .SYNC_RESET (1'b1)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .rtc_tick     (rtc_tick),
      .rtc_datetime (rtc_datetime),
      .rtc_wr       (rtc_wr),
      .rtc_addr     (rtc_addr),
      .rtc_data     (rtc_data),
      .cpu_wr       (cpu_wr),
      .cpu_addr     (cpu_addr),
      .cpu_wdata    (cpu_wdata),
      .cpu_rdata    (cpu_rdata),
      .datetime     (datetime),
      .pps          (pps),
      .alarm        (alarm)
   );

   typedef struct {
      logic [55:0] start;
      logic [55:0] want;
   } vec_t;

   vec_t vecs [12];
   int   nerr = 0;
   int   nchk = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic cpu_write(input logic [4:0] a, input logic [7:0] d);
      cpu_wr    = 1'b1;
      cpu_addr  = a;
      cpu_wdata = d;
      cycle();
      cpu_wr    = 1'b0;
   endtask

   task automatic rtc_load(input logic [55:0] dt);
      rtc_datetime = dt;
      rtc_tick     = 1'b1;
      cycle();
      rtc_tick     = 1'b0;
   endtask

   // Runs n cycles and reports whether pps was seen in any of them.
   task automatic run_quiet(input int n, output logic saw);
      saw = 1'b0;
      for (int k = 0; k < n; k++) begin
         cycle();
         if (pps) saw = 1'b1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic saw;

      vecs[0]  = '{56'h23_02_28_07_23_59_59, 56'h23_03_01_01_00_00_00};
      vecs[1]  = '{56'h24_02_28_07_23_59_59, 56'h24_02_29_01_00_00_00};
      vecs[2]  = '{56'h24_02_29_03_23_59_59, 56'h24_03_01_04_00_00_00};
      vecs[3]  = '{56'h99_12_31_05_23_59_59, 56'h00_01_01_06_00_00_00};
      vecs[4]  = '{56'h25_06_15_03_12_34_56, 56'h25_06_15_03_12_34_57};
      vecs[5]  = '{56'h25_04_30_02_23_59_59, 56'h25_05_01_03_00_00_00};
      vecs[6]  = '{56'h25_06_15_03_10_20_7A, 56'h25_06_15_03_10_21_00};
      vecs[7]  = '{56'h25_06_15_03_10_20_3A, 56'h25_06_15_03_10_20_40};
      vecs[8]  = '{56'h25_01_31_06_23_59_59, 56'h25_02_01_07_00_00_00};
      vecs[9]  = '{56'h00_06_30_01_09_59_59, 56'h00_06_30_01_10_00_00};
      vecs[10] = '{56'h00_02_28_01_23_59_59, 56'h00_02_29_02_00_00_00};
      vecs[11] = '{56'h12_02_28_04_23_59_59, 56'h12_02_29_05_00_00_00};

      reset        = 1'b0;
      rtc_tick     = 1'b0;
      rtc_datetime = '0;
      cpu_wr       = 1'b0;
      cpu_addr     = 5'd7;
      cpu_wdata    = '0;
      repeat (2) @(posedge clk);
      #1;

      check("reset datetime", datetime, DT_RESET);
      check("reset pps", pps, 0);
      check("reset alarm", alarm, 0);
      check("reset rtc_wr", rtc_wr, 0);
      check("reset rtc_addr", rtc_addr, 0);
      check("reset rtc_data", rtc_data, 0);
      check("reset cpu_rdata", cpu_rdata, 0);
      reset = 1'b1;

      run_quiet(CLK_HZ - 1, saw);
      check("first second no early pps", saw, 0);
      check("ctrl sync_en reset value", cpu_rdata, 8'h01);
      cycle();
      check("first second pps", pps, 1);
      check("first second datetime", datetime, 56'h00_01_01_01_00_00_01);
      check("first second alarm", alarm, 0);

      for (int i = 0; i < 12; i++) begin
         rtc_load(vecs[i].start);
         check($sformatf("vec%0d load", i), datetime, vecs[i].start);
         run_quiet(CLK_HZ - 1, saw);
         check($sformatf("vec%0d no early pps", i), saw, 0);
         cycle();
         check($sformatf("vec%0d pps", i), pps, 1);
         check($sformatf("vec%0d datetime", i), datetime, vecs[i].want);
      end
      check("disabled alarms stay clear", alarm, 0);

      cpu_write(5'd7, 8'h00);
      rtc_load(56'h25_06_15_03_12_34_56);
      check("sync disabled ignores tick", datetime, vecs[11].want);
      check("ctrl readback 0", cpu_rdata, 8'h00);
      cpu_write(5'd7, 8'h01);
      cycle();
      check("ctrl readback 1", cpu_rdata, 8'h01);

      rtc_load(56'h25_06_15_03_12_00_00);
      cpu_write(5'd1, 8'h45);
      check("mi write", datetime, 56'h25_06_15_03_12_45_00);
      check("mi rtc_wr", rtc_wr, 1);
      check("mi rtc_addr", rtc_addr, 1);
      check("mi rtc_data", rtc_data, 8'h45);
      cycle();
      check("rtc_wr single pulse", rtc_wr, 0);
      cpu_write(5'd4, 8'h16);
      check("b2b first rtc_wr", {rtc_wr, rtc_addr, rtc_data}, {1'b1, 3'd4, 8'h16});
      cpu_write(5'd5, 8'h07);
      check("b2b second rtc_wr", {rtc_wr, rtc_addr, rtc_data}, {1'b1, 3'd5, 8'h07});
      cycle();
      check("b2b rtc_wr ends", rtc_wr, 0);
      check("b2b datetime", datetime, 56'h25_07_16_03_12_45_00);
      run_quiet(4, saw);
      check("no pps before coincident write", saw, 0);
      cpu_write(5'd2, 8'h13);
      check("pps deferred by write", pps, 0);
      check("write wins increment slot", datetime, 56'h25_07_16_03_13_45_00);
      cycle();
      check("deferred pps pulses", pps, 1);
      check("deferred increment applied", datetime, 56'h25_07_16_03_13_45_01);

      cpu_write(5'd16, 8'h05);
      cpu_write(5'd17, 8'h00);
      cpu_write(5'd18, 8'h12);
      cpu_write(5'd8, 8'h01);
      cpu_addr = 5'd18;
      cycle();
      check("alarm0 HH readback", cpu_rdata, 8'h12);
      rtc_load(56'h25_07_16_03_12_00_04);
      check("load does not fire alarm", alarm, 0);
      run_quiet(CLK_HZ - 1, saw);
      cycle();
      check("alarm second pps", pps, 1);
      check("alarm second datetime", datetime, 56'h25_07_16_03_12_00_05);
      cycle();
      check("alarm0 fires", alarm, 2'b01);
      cpu_addr = 5'd9;
      cycle();
      check("alarm flag readback", cpu_rdata, 8'h01);
      cpu_write(5'd9, 8'h01);
      check("alarm flag cleared", alarm, 0);
      cycle();
      check("alarm flag reads 0", cpu_rdata, 8'h00);

      cpu_wr    = 1'b1;
      cpu_addr  = 5'd3;
      cpu_wdata = 8'h05;
      cycle();
      cpu_wr = 1'b0;
      check("rtc_wr pending before reset", rtc_wr, 1);
      reset = 1'b0;
      #1;
      check("async reset datetime", datetime, DT_RESET);
      check("async reset rtc_wr", rtc_wr, 0);
      check("async reset rtc_addr", rtc_addr, 0);
      check("async reset rtc_data", rtc_data, 0);
      check("async reset cpu_rdata", cpu_rdata, 0);
      check("async reset pps/alarm", {pps, alarm}, 0);
      cycle();
      cycle();
      reset    = 1'b1;
      cpu_addr = 5'd8;
      saw      = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cycle();
         if (rtc_wr) saw = 1'b1;
      end
      check("no rtc_wr after reset release", saw, 0);
      check("datetime after reset release", datetime, DT_RESET);
      check("alarm_en reset value", cpu_rdata, 8'h00);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
